// File: rtl/vga_pkg.sv
// Shared types, default 640x480 timing and elaboration helpers for the
// scaled VGA timing generator.
package vga_pkg;

    // Region of one axis within a line (horizontal) or a frame (vertical).
    typedef enum logic [1:0] {
        RGN_ACTIVE = 2'd0,
        RGN_FP     = 2'd1,
        RGN_SYNC   = 2'd2,
        RGN_BP     = 2'd3
    } region_e;

    // Per-pixel video flags carried down the RAM-latency delay line.
    typedef struct packed {
        logic frame_start;
        logic disp_en;
        logic vsync;
        logic hsync;
    } vid_flags_t;

    // Default 640x480 @ 4 clocks/pixel, 128x96 framebuffer scaled by 5.
    localparam int DEF_CLK_PER_PIX = 4;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_FB_W        = 128;
    localparam int DEF_FB_H        = 96;
    localparam int DEF_SCALE       = 5;

    // Ceiling log2; 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int bits_for(input int n);
        int w;
        w = clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Period of one axis in pixels or lines.
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Horizontal period in pixels.
    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

    // Vertical period in lines.
    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return axis_total(active, fp, sync, bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter, ACTIVE/FP/SYNC/BP region FSM and the
// scale sub-counter that divides the active span into framebuffer cells.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int SCALE  = DEF_SCALE,
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int CNT_W = bits_for(TOTAL)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o,
    output region_e          region_o,
    output logic             sync_o,
    output logic             active_o,
    output logic             scale_wrap_o
);

    localparam int SC_W = bits_for(SCALE);
    localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP     = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_BP     = CNT_W'(TOTAL - 1);
    localparam logic [SC_W-1:0]  LAST_SC     = SC_W'(SCALE - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [SC_W-1:0]  sc_q, sc_d;
    region_e          region_q, region_d;
    logic             wrap_s;
    logic             scale_wrap_s;

    assign wrap_s       = step_i && (count_q == LAST_BP);
    assign scale_wrap_s = step_i && (region_q == RGN_ACTIVE) && (sc_q == LAST_SC);

    assign count_o      = count_q;
    assign wrap_o       = wrap_s;
    assign region_o     = region_q;
    assign scale_wrap_o = scale_wrap_s;

    // State register: position, scale sub-counter and region.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q  <= '0;
            sc_q     <= '0;
            region_q <= RGN_ACTIVE;
        end else begin
            count_q  <= count_d;
            sc_q     <= sc_d;
            region_q <= region_d;
        end
    end

    // Position advances per step; the scale sub-counter only runs in ACTIVE.
    always_comb begin
        count_d = count_q;
        sc_d    = sc_q;
        if (wrap_s) begin
            count_d = '0;
            sc_d    = '0;
        end else if (step_i) begin
            count_d = count_q + CNT_W'(1'b1);
            if (scale_wrap_s) begin
                sc_d = '0;
            end else if (region_q == RGN_ACTIVE) begin
                sc_d = sc_q + SC_W'(1'b1);
            end else begin
                sc_d = sc_q;
            end
        end else begin
            count_d = count_q;
            sc_d    = sc_q;
        end
    end

    // Region next state: move on when the last position of a region is stepped past.
    always_comb begin
        region_d = region_q;
        if (step_i) begin
            case (region_q)
                RGN_ACTIVE: if (count_q == LAST_ACTIVE) region_d = RGN_FP;     else region_d = RGN_ACTIVE;
                RGN_FP:     if (count_q == LAST_FP)     region_d = RGN_SYNC;   else region_d = RGN_FP;
                RGN_SYNC:   if (count_q == LAST_SYNC)   region_d = RGN_BP;     else region_d = RGN_SYNC;
                RGN_BP:     if (count_q == LAST_BP)     region_d = RGN_ACTIVE; else region_d = RGN_BP;
                default:    region_d = RGN_ACTIVE;
            endcase
        end else begin
            region_d = region_q;
        end
    end

    // Region outputs decoded from the state register only.
    always_comb begin
        sync_o   = 1'b0;
        active_o = 1'b0;
        case (region_q)
            RGN_ACTIVE: active_o = 1'b1;
            RGN_SYNC:   sync_o   = 1'b1;
            default: begin
                sync_o   = 1'b0;
                active_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/vga_scaled_timing.sv
// VGA timing generator with integer-scaled framebuffer addressing and
// animation frame sequencing. Syncs, disp_en and frame_start are delayed by
// RAM_LAT clocks so they line up with the VRAM read data for fb_addr.
module vga_scaled_timing
    import vga_pkg::*;
#(
    parameter int CLK_PER_PIX     = DEF_CLK_PER_PIX,
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int FB_W            = DEF_FB_W,
    parameter int FB_H            = DEF_FB_H,
    parameter int SCALE_H         = DEF_SCALE,
    parameter int SCALE_V         = DEF_SCALE,
    parameter int NUM_FRAMES      = 4,
    parameter int FRAME_HOLD      = 60,
    parameter int RAM_LAT         = 1,
    parameter int SYNC_ACTIVE_LOW = 1,
    localparam int ADDR_W         = bits_for(FB_W * FB_H),
    localparam int FS_W           = bits_for(NUM_FRAMES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    output logic              hsync,
    output logic              vsync,
    output logic              disp_en,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [FS_W-1:0]   frame_sel,
    output logic              frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_CNT_W = bits_for(H_TOTAL);
    localparam int V_CNT_W = bits_for(V_TOTAL);
    localparam int PRE_W   = bits_for(CLK_PER_PIX);
    localparam int HOLD_W  = bits_for(FRAME_HOLD);
    localparam int COL_W   = bits_for(FB_W + 1);
    localparam int ROW_W   = bits_for(FB_W * FB_H + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_PER_PIX - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [FS_W-1:0]   FS_LAST   = FS_W'(NUM_FRAMES - 1);
    localparam logic [ROW_W-1:0]  ROW_STEP  = ROW_W'(FB_W);
    localparam logic              SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam vid_flags_t FLAGS_RESET = '{frame_start: 1'b0, disp_en: 1'b0,
                                           vsync: SYNC_IDLE, hsync: SYNC_IDLE};

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               tick_s;
    logic [H_CNT_W-1:0] h_count_s;
    logic [V_CNT_W-1:0] v_count_s;
    logic               h_wrap_s, v_wrap_s;
    region_e            h_region_s, v_region_s;
    logic               h_sync_s, v_sync_s;
    logic               h_active_s, v_active_s;
    logic               h_scale_wrap_s, v_scale_wrap_s;
    logic               pix_visible_s;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
    vid_flags_t         flags0_q, flags0_d;
    vid_flags_t         flags_out_s;
    logic               anim_evt_q;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [FS_W-1:0]    frame_sel_q, frame_sel_d;

    assign tick_s = (pre_q == PRE_LAST);

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .SCALE  (SCALE_H)
    ) u_h_axis (
        .clk_i        (clk),
        .reset_i      (reset),
        .step_i       (tick_s),
        .count_o      (h_count_s),
        .wrap_o       (h_wrap_s),
        .region_o     (h_region_s),
        .sync_o       (h_sync_s),
        .active_o     (h_active_s),
        .scale_wrap_o (h_scale_wrap_s)
    );

    // The vertical axis steps once per line, on the horizontal wrap.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .SCALE  (SCALE_V)
    ) u_v_axis (
        .clk_i        (clk),
        .reset_i      (reset),
        .step_i       (h_wrap_s),
        .count_o      (v_count_s),
        .wrap_o       (v_wrap_s),
        .region_o     (v_region_s),
        .sync_o       (v_sync_s),
        .active_o     (v_active_s),
        .scale_wrap_o (v_scale_wrap_s)
    );

    assign pix_visible_s = (h_region_s == RGN_ACTIVE) && (v_region_s == RGN_ACTIVE);

    // Prescaler: one tick every CLK_PER_PIX clocks.
    always_comb begin
        pre_d = pre_q;
        if (tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PRE_W'(1'b1);
        end
    end

    // Address accumulator: column steps per horizontal cell, row base adds FB_W per vertical cell.
    always_comb begin
        col_d      = col_q;
        row_base_d = row_base_q;
        if (h_wrap_s) begin
            col_d = '0;
        end else if (h_scale_wrap_s) begin
            col_d = col_q + COL_W'(1'b1);
        end else begin
            col_d = col_q;
        end
        if (v_wrap_s) begin
            row_base_d = '0;
        end else if (v_scale_wrap_s) begin
            row_base_d = row_base_q + ROW_STEP;
        end else begin
            row_base_d = row_base_q;
        end
    end

    // Stage-0 outputs: address (held through blanking) and flags for the current position.
    always_comb begin
        fb_addr_d = fb_addr_q;
        flags0_d  = FLAGS_RESET;
        if (pix_visible_s) begin
            fb_addr_d = ADDR_W'(row_base_q + ROW_W'(col_q));
        end else begin
            fb_addr_d = fb_addr_q;
        end
        flags0_d.hsync       = h_sync_s ? ~SYNC_IDLE : SYNC_IDLE;
        flags0_d.vsync       = v_sync_s ? ~SYNC_IDLE : SYNC_IDLE;
        flags0_d.disp_en     = h_active_s && v_active_s;
        flags0_d.frame_start = (h_count_s == '0) && (v_count_s == '0) && (pre_q == '0);
    end

    // Animation: the frame wrap, registered, lands on the same edge as stage-0 frame_start.
    always_comb begin
        hold_d      = hold_q;
        frame_sel_d = frame_sel_q;
        if (anim_evt_q && !freeze) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                if (frame_sel_q == FS_LAST) begin
                    frame_sel_d = '0;
                end else begin
                    frame_sel_d = frame_sel_q + FS_W'(1'b1);
                end
            end else begin
                hold_d      = hold_q + HOLD_W'(1'b1);
                frame_sel_d = frame_sel_q;
            end
        end else begin
            hold_d      = hold_q;
            frame_sel_d = frame_sel_q;
        end
    end

    // Top-level state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            fb_addr_q   <= '0;
            flags0_q    <= FLAGS_RESET;
            anim_evt_q  <= 1'b0;
            hold_q      <= '0;
            frame_sel_q <= '0;
        end else begin
            pre_q       <= pre_d;
            col_q       <= col_d;
            row_base_q  <= row_base_d;
            fb_addr_q   <= fb_addr_d;
            flags0_q    <= flags0_d;
            anim_evt_q  <= v_wrap_s;
            hold_q      <= hold_d;
            frame_sel_q <= frame_sel_d;
        end
    end

    generate
        if (RAM_LAT == 0) begin : g_no_delay
            assign flags_out_s = flags0_q;
        end else begin : g_delay
            vid_flags_t dl_q [RAM_LAT];

            // Delay line matching the VRAM read latency.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < RAM_LAT; i++) begin
                        dl_q[i] <= FLAGS_RESET;
                    end
                end else begin
                    dl_q[0] <= flags0_q;
                    for (int i = 1; i < RAM_LAT; i++) begin
                        dl_q[i] <= dl_q[i-1];
                    end
                end
            end

            assign flags_out_s = dl_q[RAM_LAT-1];
        end
    endgenerate

    assign hsync       = flags_out_s.hsync;
    assign vsync       = flags_out_s.vsync;
    assign disp_en     = flags_out_s.disp_en;
    assign frame_start = flags_out_s.frame_start;
    assign fb_addr     = fb_addr_q;
    assign frame_sel   = frame_sel_q;

endmodule

// File: tb/tb_vga_scaled_timing.sv
// Randomised bench for vga_scaled_timing on a small timing configuration,
// compared every clock against an arithmetic model of the raster.
`timescale 1ns/1ps
module tb_vga_scaled_timing;

    localparam int CPP = 2;
    localparam int HA = 8, HFP = 1, HS = 2, HBP = 1;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int FBW = 4, FBH = 2, SH = 2, SV = 2;
    localparam int NF = 3, FH = 2, LAT = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME_PIX = HT * VT;
    localparam int ADDR_W = 3, FS_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              freeze;
    logic              hsync, vsync, disp_en, frame_start;
    logic [ADDR_W-1:0] fb_addr;
    logic [FS_W-1:0]   frame_sel;
    logic [ADDR_W-1:0] vram_pipe [LAT];

    int chk_cnt = 0;
    int err_cnt = 0;
    int n_edges = 0;
    int m_sel = 0;
    int m_hold = 0;

    vga_scaled_timing #(
        .CLK_PER_PIX (CPP),
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .FB_W (FBW), .FB_H (FBH), .SCALE_H (SH), .SCALE_V (SV),
        .NUM_FRAMES (NF), .FRAME_HOLD (FH), .RAM_LAT (LAT),
        .SYNC_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .freeze      (freeze),
        .hsync       (hsync),
        .vsync       (vsync),
        .disp_en     (disp_en),
        .fb_addr     (fb_addr),
        .frame_sel   (frame_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Behavioural VRAM returning the address as data after LAT clocks.
    always @(posedge clk) begin
        vram_pipe[0] <= fb_addr;
        for (int i = 1; i < LAT; i++) begin
            vram_pipe[i] <= vram_pipe[i-1];
        end
    end

    task automatic check_eq(input string tag, input int actual, input int expected);
        chk_cnt++;
        if (actual != expected) begin
            err_cnt++;
            if (err_cnt <= 40) begin
                $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
            end
        end
    endtask

    // Pixel shown after the m-th clock edge since reset release (m >= 1).
    function automatic void pix_of(input int m, output int h, output int v, output int ph, output int frame);
        int p, q;
        p     = (m - 1) / CPP;
        ph    = (m - 1) % CPP;
        frame = p / FRAME_PIX;
        q     = p % FRAME_PIX;
        h     = q % HT;
        v     = q / HT;
    endfunction

    // Address on fb_addr for a raster position; blanking holds the last visible address.
    function automatic int exp_addr(input int h, input int v);
        if (v < VA && h < HA) return (v / SV) * FBW + h / SH;
        else if (v < VA)      return (v / SV) * FBW + (HA - 1) / SH;
        else                  return FBW * FBH - 1;
    endfunction

    task automatic check_reset_outputs();
        check_eq("rst_hsync", int'(hsync), 1);
        check_eq("rst_vsync", int'(vsync), 1);
        check_eq("rst_disp_en", int'(disp_en), 0);
        check_eq("rst_frame_start", int'(frame_start), 0);
        check_eq("rst_fb_addr", int'(fb_addr), 0);
        check_eq("rst_frame_sel", int'(frame_sel), 0);
    endtask

    task automatic step_cycle(input bit allow_freeze);
        int h, v, ph, fr, m, v0;
        @(posedge clk);
        n_edges++;
        pix_of(n_edges, h, v, ph, fr);
        v0 = v;
        if (fr >= 1 && h == 0 && v == 0 && ph == 0 && freeze == 1'b0) begin
            if (m_hold == FH - 1) begin
                m_hold = 0;
                m_sel  = (m_sel + 1) % NF;
            end else begin
                m_hold++;
            end
        end
        @(negedge clk);
        check_eq("fb_addr", int'(fb_addr), exp_addr(h, v));
        check_eq("frame_sel", int'(frame_sel), m_sel);
        m = n_edges - LAT;
        if (m >= 1) begin
            pix_of(m, h, v, ph, fr);
            check_eq("hsync", int'(hsync), (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1);
            check_eq("vsync", int'(vsync), (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1);
            check_eq("disp_en", int'(disp_en), (h < HA && v < VA) ? 1 : 0);
            check_eq("frame_start", int'(frame_start), (h == 0 && v == 0 && ph == 0) ? 1 : 0);
            if (disp_en === 1'b1) begin
                check_eq("vram_data", int'(vram_pipe[LAT-1]), (h / SH) + (v / SV) * FBW);
            end
        end else begin
            check_eq("lat_hsync", int'(hsync), 1);
            check_eq("lat_disp_en", int'(disp_en), 0);
            check_eq("lat_frame_start", int'(frame_start), 0);
        end
        if (allow_freeze && v0 == 2 && $urandom_range(0, 99) < 3) begin
            freeze = ~freeze;
        end
    endtask

    task automatic reset_mid_hsync();
        int budget;
        budget = 0;
        while (hsync !== 1'b0 && budget < 4 * HT * CPP) begin
            step_cycle(1'b1);
            budget++;
        end
        check_eq("hsync_wait", int'(hsync), 0);
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset   = 1'b0;
        n_edges = 0;
        m_sel   = 0;
        m_hold  = 0;
    endtask

    initial begin
        int run;
        reset  = 1'b1;
        freeze = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;
        // Eight frames without freeze: frame_sel walks 0,0,1,1,2,2,0,0.
        repeat (8 * FRAME_PIX * CPP) step_cycle(1'b0);
        for (int seg = 0; seg < 5; seg++) begin
            run = int'($urandom_range(200, 900));
            repeat (run) step_cycle(1'b1);
            reset_mid_hsync();
        end
        repeat (4 * FRAME_PIX * CPP) step_cycle(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
        $finish;
    end

endmodule
